// File: rtl/spike_window_classifier_if.sv
// Handshake and data bundle between a spiking network's output layer and the
// window classifier. The master side drives the requests and spikes; the slave side returns the result.
interface spike_window_classifier_if #(
  parameter int N_OUTPUTS = 4,
  parameter int CLS_W     = 2,
  parameter int CNT_W     = 8
) ();
  logic                 start;
  logic [N_OUTPUTS-1:0] spikes;
  logic                 busy;
  logic                 class_valid;
  logic                 class_ready;
  logic [CLS_W-1:0]     class_id;
  logic [CNT_W-1:0]     class_count;
  logic                 tie;
  logic                 no_spike;

  modport master (
    output start, spikes, class_ready,
    input  busy, class_valid, class_id, class_count, tie, no_spike
  );

  modport slave (
    input  start, spikes, class_ready,
    output busy, class_valid, class_id, class_count, tie, no_spike
  );
endinterface

// File: rtl/spike_window_classifier.sv
// Counts per-class output spikes over a fixed window and reports the argmax class.
// Optional macro SPIKE_CLASSIFIER_EARLY_EXIT_EN ends the window once any count reaches EARLY_THRESH.
module spike_window_classifier #(
  parameter int N_OUTPUTS    = 4,
  parameter int CLS_W        = 2,
  parameter int CNT_W        = 8,
  parameter int WINDOW       = 100,
  parameter int EARLY_THRESH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  spike_window_classifier_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DECIDE, S_DONE} state_t;

  localparam logic [15:0] WIN_LAST = 16'(WINDOW - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt [N_OUTPUTS];
  logic [15:0]      r_win;
  logic             r_busy;
  logic             r_valid;
  logic [CLS_W-1:0] r_id;
  logic [CNT_W-1:0] r_count;
  logic             r_tie;
  logic             r_no_spike;

  logic [CNT_W-1:0] w_cnt_nxt [N_OUTPUTS];
  logic [CLS_W-1:0] w_max_id;
  logic [CNT_W-1:0] w_max_cnt;
  logic             w_tie;
  logic             w_window_end;
  logic             w_go_decide;

  // Saturating increment; the all-ones value holds instead of wrapping.
  always_comb begin
    for (int i = 0; i < N_OUTPUTS; i++) begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      w_cnt_nxt[i] = r_cnt[i];
      if (bus.spikes[i] && (r_cnt[i] != '1))
        w_cnt_nxt[i] = r_cnt[i] + 1'b1;
    end
  end

  // Strict '>' keeps the lowest index on equal counts.
  always_comb begin
    w_max_id  = '0;
    w_max_cnt = r_cnt[0];
    w_tie     = 1'b0;
    for (int i = 1; i < N_OUTPUTS; i++) begin
      if (r_cnt[i] > w_max_cnt) begin
        w_max_cnt = r_cnt[i];
        w_max_id  = CLS_W'(i);
      end
    end
    for (int i = 0; i < N_OUTPUTS; i++) begin
      if ((r_cnt[i] == w_max_cnt) && (CLS_W'(i) != w_max_id))
        w_tie = 1'b1;
    end
    if (w_max_cnt == '0)
      w_tie = 1'b0;
  end

  assign w_window_end = (r_win == WIN_LAST);

`ifdef SPIKE_CLASSIFIER_EARLY_EXIT_EN
  localparam logic [31:0] EARLY_LIM = 32'(EARLY_THRESH);

  logic w_early;

  // Looks at next-cycle counts so the exit happens on the edge the threshold is reached.
  always_comb begin
    w_early = 1'b0;
    for (int i = 0; i < N_OUTPUTS; i++) begin
      if (32'(w_cnt_nxt[i]) >= EARLY_LIM)
        w_early = 1'b1;
    end
  end

  assign w_go_decide = w_window_end | w_early;
`else
  logic w_unused_thresh;
  assign w_unused_thresh = (EARLY_THRESH != 0);
  assign w_go_decide     = w_window_end;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_win      <= '0;
      // NOTE: the counter array is plain flops, so it is reset like any other register.
      for (int i = 0; i < N_OUTPUTS; i++)
        r_cnt[i] <= '0;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_id       <= '0;
      r_count    <= '0;
      r_tie      <= 1'b0;
      r_no_spike <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop reading pre-edge values.
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state <= S_COUNT;
            r_busy  <= 1'b1;
            r_win   <= '0;
            for (int i = 0; i < N_OUTPUTS; i++)
              r_cnt[i] <= '0;
          end
        end
        S_COUNT: begin
          for (int i = 0; i < N_OUTPUTS; i++)
            r_cnt[i] <= w_cnt_nxt[i];
          r_win <= r_win + 1'b1;
          if (w_go_decide)
            r_state <= S_DECIDE;
        end
        S_DECIDE: begin
          r_id       <= w_max_id;
          r_count    <= w_max_cnt;
          r_tie      <= w_tie;
          r_no_spike <= (w_max_cnt == '0);
          r_valid    <= 1'b1;
          r_state    <= S_DONE;
        end
        S_DONE: begin
          if (bus.class_ready) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.class_valid = r_valid;
  assign bus.class_id    = r_id;
  assign bus.class_count = r_count;
  assign bus.tie         = r_tie;
  assign bus.no_spike    = r_no_spike;

endmodule

// File: tb/tb_spike_window_classifier.sv
// Directed scoreboard bench for spike_window_classifier: window results, tie/no-spike,
// saturation, held results under back-pressure and mid-window reset.
module tb_spike_window_classifier;

  localparam int WINDOW = 10;
  localparam int LAT    = WINDOW + 2;

  typedef logic [3:0] pat_t [WINDOW];
  typedef struct {
    logic [1:0] id;
    logic [7:0] cnt;
    logic       tie;
    logic       nsp;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  exp_t sb_q [$];

  spike_window_classifier_if #(.N_OUTPUTS(4), .CLS_W(2), .CNT_W(8)) bus   ();
  spike_window_classifier_if #(.N_OUTPUTS(4), .CLS_W(2), .CNT_W(4)) bus_s ();

  spike_window_classifier #(
    .N_OUTPUTS(4), .CLS_W(2), .CNT_W(8), .WINDOW(WINDOW), .EARLY_THRESH(32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  spike_window_classifier #(
    .N_OUTPUTS(4), .CLS_W(2), .CNT_W(4), .WINDOW(20), .EARLY_THRESH(32)
  ) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

`ifdef SPIKE_CLASSIFIER_EARLY_EXIT_EN
  spike_window_classifier_if #(.N_OUTPUTS(4), .CLS_W(2), .CNT_W(8)) bus_e ();

  spike_window_classifier #(
    .N_OUTPUTS(4), .CLS_W(2), .CNT_W(8), .WINDOW(WINDOW), .EARLY_THRESH(3)
  ) dut_early (
    .clk (clk),
    .rst (rst),
    .bus (bus_e)
  );
`endif

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] id, input logic [7:0] cnt, input logic tie, input logic nsp);
    exp_t e;
    e.id  = id;
    e.cnt = cnt;
    e.tie = tie;
    e.nsp = nsp;
    e.lat = LAT;
    return e;
  endfunction

  // Reference: saturating per-class totals, then lowest-index argmax.
  function automatic exp_t model(input pat_t p);
    int   c [4];
    int   mx = 0;
    int   n  = 0;
    exp_t e;
    for (int i = 0; i < 4; i++) c[i] = 0;
    for (int k = 0; k < WINDOW; k++)
      for (int i = 0; i < 4; i++)
        if (p[k][i] && c[i] < 255) c[i]++;
    e.id = 2'd0;
    for (int i = 0; i < 4; i++)
      if (c[i] > mx) begin
        mx   = c[i];
        e.id = 2'(i);
      end
    for (int i = 0; i < 4; i++)
      if (c[i] == mx) n++;
    e.cnt = 8'(mx);
    e.tie = (n > 1) && (mx > 0);
    e.nsp = (mx == 0);
    e.lat = LAT;
    return e;
  endfunction

  function automatic pat_t fill(input logic [3:0] v);
    pat_t p;
    for (int k = 0; k < WINDOW; k++) p[k] = v;
    return p;
  endfunction

  task automatic run_window(input string tag, input pat_t p, input exp_t e);
    int   k;
    exp_t got;
    sb_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      bus.start = 1'b0;
      if (k <= WINDOW) bus.spikes = p[k-1];
      else             bus.spikes = 4'b1111;
    end while (!bus.class_valid && k < 4 * LAT);
    got = sb_q.pop_front();
    check({tag, "_latency"}, k, got.lat);
    check({tag, "_id"},      bus.class_id, got.id);
    check({tag, "_count"},   bus.class_count, got.cnt);
    check({tag, "_tie"},     bus.tie, got.tie);
    check({tag, "_nospike"}, bus.no_spike, got.nsp);
  endtask

  task automatic check_idle_after(input string tag);
    @(negedge clk);
    check({tag, "_busy_drop"},  bus.busy, 1'b0);
    check({tag, "_valid_drop"}, bus.class_valid, 1'b0);
  endtask

  initial begin
    int k;
    int seen;

    bus.start = 1'b0;   bus.spikes = 4'b0;   bus.class_ready = 1'b1;
    bus_s.start = 1'b0; bus_s.spikes = 4'b0; bus_s.class_ready = 1'b1;
`ifdef SPIKE_CLASSIFIER_EARLY_EXIT_EN
    bus_e.start = 1'b0; bus_e.spikes = 4'b0; bus_e.class_ready = 1'b1;
`endif

    #2;
    check("rst_busy",    bus.busy, 1'b0);
    check("rst_valid",   bus.class_valid, 1'b0);
    check("rst_id",      bus.class_id, 2'd0);
    check("rst_count",   bus.class_count, 8'd0);
    check("rst_tie",     bus.tie, 1'b0);
    check("rst_nospike", bus.no_spike, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    run_window("single", fill(4'b0100), mk(2'd2, 8'd10, 1'b0, 1'b0));
    check_idle_after("single");

    run_window("silent", fill(4'b0000), mk(2'd0, 8'd0, 1'b0, 1'b1));
    check_idle_after("silent");

    run_window("tied", fill(4'b1010), mk(2'd1, 8'd10, 1'b1, 1'b0));
    check_idle_after("tied");

    begin
      pat_t p;
      p = '{4'b0011, 4'b0110, 4'b1100, 4'b1001, 4'b0010,
            4'b0010, 4'b0111, 4'b1000, 4'b0010, 4'b0001};
      run_window("mixed", p, model(p));
      check_idle_after("mixed");
    end

    // Back-pressure: result must hold and start pulses must be ignored.
    bus.class_ready = 1'b0;
    run_window("hold", fill(4'b0010), mk(2'd1, 8'd10, 1'b0, 1'b0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.start = (i % 2 == 0);
      check("hold_valid", bus.class_valid, 1'b1);
      check("hold_busy",  bus.busy, 1'b1);
      check("hold_id",    bus.class_id, 2'd1);
      check("hold_count", bus.class_count, 8'd10);
    end
    bus.start = 1'b0;
    bus.class_ready = 1'b1;
    check_idle_after("hold");
    @(negedge clk);
    check("hold_no_restart", bus.busy, 1'b0);

    // Asynchronous reset in the middle of a window.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.spikes = 4'b1000;
    repeat (5) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    #1 rst = 1'b1;
    #1;
    check("arst_busy",  bus.busy, 1'b0);
    check("arst_valid", bus.class_valid, 1'b0);
    check("arst_count", bus.class_count, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (WINDOW + 5) begin
      @(negedge clk);
      if (bus.class_valid) seen++;
    end
    check("arst_discard", seen, 0);
    check("arst_queue",   sb_q.size(), 0);
    run_window("restart", fill(4'b0001), mk(2'd0, 8'd10, 1'b0, 1'b0));
    check_idle_after("restart");

    // Saturation on the narrow-counter instance.
    @(negedge clk);
    bus_s.start  = 1'b1;
    bus_s.spikes = 4'b0001;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      bus_s.start = 1'b0;
    end while (!bus_s.class_valid && k < 60);
    check("sat_latency", k, 22);
    check("sat_count",   bus_s.class_count, 4'd15);
    check("sat_id",      bus_s.class_id, 2'd0);
    check("sat_tie",     bus_s.tie, 1'b0);
    @(negedge clk);
    check("sat_busy_drop", bus_s.busy, 1'b0);

`ifdef SPIKE_CLASSIFIER_EARLY_EXIT_EN
    @(negedge clk);
    bus_e.start  = 1'b1;
    bus_e.spikes = 4'b0001;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      bus_e.start = 1'b0;
    end while (!bus_e.class_valid && k < 40);
    check("early_latency", k, 5);
    check("early_count",   bus_e.class_count, 8'd3);
    check("early_id",      bus_e.class_id, 2'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
